pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB).
- Consumes decode-stage register-read/write info, EX-stage load/jump info and the multi-cycle divider's completion handshake.
- Maintains a register scoreboard and a divider-occupancy FSM, and drives per-stage stall and flush vectors to the pipeline registers.
- Replaces ad-hoc per-stage hold logic with one arbiter of pipeline progress.

Parameters:
- REG_NUM, 32, number of integer registers tracked by the scoreboard.
- REG_AW, 5, register address width.
- DIV_TIMEOUT, 80, cycles the divider may stay busy before a timeout error is declared.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- id_valid_i  in  1  ID holds a real instruction (not a bubble).
- id_reg1_raddr_i  in  REG_AW  rs1 address from decode.
- id_reg1_read_i  in  1  rs1 is actually read.
- id_reg2_raddr_i  in  REG_AW  rs2 address from decode.
- id_reg2_read_i  in  1  rs2 is actually read.
- id_reg_we_i  in  1  ID instruction writes rd.
- id_reg_waddr_i  in  REG_AW  rd from decode.
- id_is_div_i  in  1  ID instruction is DIV/DIVU/REM/REMU or a W variant.
- ex_is_load_i  in  1  EX holds a load.
- ex_reg_we_i  in  1  EX writes rd.
- ex_reg_waddr_i  in  REG_AW  EX rd.
- ex_jump_i  in  1  EX resolved a taken branch, JAL or JALR.
- div_done_i  in  1  divider result valid (1-cycle pulse).
- div_start_o  out  1  launch the divider (1-cycle pulse).
- stall_o  out  5  {wb,mem,ex,id,if}; 1 = hold that pipeline register.
- flush_o  out  5  same order; 1 = load a bubble.
- div_busy_o  out  1  FSM not IDLE.
- div_timeout_o  out  1  sticky timeout error.

Behaviour:
- Reset (rst_n low, async):
  - scoreboard sb[REG_NUM-1:0] = 0, FSM = IDLE, div_rd_q = 0, wd_cnt = 0, div_timeout_o = 0.
  - All outputs forced to 0 while rst_n is low.
- Register x0 is never tracked:
  - No scoreboard set for rd = 0.
  - No hazard match on address 0.
- Hazard terms (combinational, from registered state plus current inputs):
  - raw_sb: id_valid_i, and (rs1 read with sb[rs1]) or (rs2 read with sb[rs2]).
  - waw_sb: id_valid_i & id_reg_we_i & sb[rd].
  - load_use: ex_is_load_i & ex_reg_we_i & ex_reg_waddr_i != 0 & ex_reg_waddr_i equals an actually-read rs.
  - div_struct: id_valid_i & id_is_div_i & FSM = BUSY & !div_done_i.
- Priority, highest first:
  - ex_jump_i: flush_o = 5'b00110 (ID, EX), stall_o = 0.
  - raw_sb | waw_sb | div_struct: stall_o = 5'b00011, flush_o = 5'b00100 (bubble into EX).
  - load_use: same stall/flush pattern; lasts exactly 1 cycle because the load advances.
  - Otherwise all zeros.
- Issue:
  - A div issues when id_valid_i & id_is_div_i, stall_o[1] = 0 and ex_jump_i = 0.
  - On issue: div_start_o = 1 the same cycle; at the next edge sb[rd] is set (if rd != 0), div_rd_q = rd, FSM goes to BUSY, wd_cnt = 0.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY on issue.
  - BUSY & div_done_i: clear sb[div_rd_q]. If an issue happens in the same cycle, stay BUSY, reload div_rd_q and wd_cnt = 0. Otherwise go to IDLE.
  - Set and clear of the same index in one cycle: set wins.
  - BUSY & !div_done_i: wd_cnt increments (saturating).
  - At wd_cnt = DIV_TIMEOUT-1: set div_timeout_o (sticky until reset), clear sb[div_rd_q], go to IDLE.
  - A div_done_i that arrives late, while in IDLE, is ignored.
- A jump in the same cycle as a div issue suppresses the issue: no start pulse, no scoreboard set.
- Only one divide is ever outstanding.
- Latency: stall/flush outputs are combinational (0 cycles). Scoreboard effects are visible from the cycle after the issuing edge.

Decomposition:
- Shared package/defines:
  - Stage index constants STG_IF..STG_WB (0..4).
  - FSM state encoding.
  - STALL_* / FLUSH_* pattern constants.
  - REG_AW, and the NOPRegAddr zero constant.
- One natural sub-module: reg_scoreboard (REG_NUM-bit set/clear vector with two read ports plus a write-check port, set-wins rule).

Test Plan:
- Load-use: EX = load with rd=5; ID reads rs1=5 -> stall_o = 00011 and flush_o = 00100 for exactly 1 cycle, then both 0.
- DIV x7 issued, then ADD reading x7 -> div_start_o pulses once, sb[7] = 1, stall_o = 00011 each cycle until div_done_i; sb[7] = 0 the cycle after, and the ADD proceeds.
- Back-to-back divides: second div waits while BUSY; on the done cycle it issues -> div_start_o = 1 on the same cycle as div_done_i and FSM stays BUSY. With the same rd=9 in both divides, sb[9] remains 1.
- Jump during a scoreboard stall: ex_jump_i = 1 -> flush_o = 00110 and stall_o = 0. A div in ID is not issued, and sb is unchanged.
- Timeout: div issued with rd=3, div_done_i never asserted -> after 80 BUSY cycles div_timeout_o = 1 (sticky), sb[3] = 0 and FSM = IDLE. A later stray div_done_i is ignored.
- Reset mid-operation: rst_n low while BUSY with sb[4] = 1 -> all outputs 0 immediately; after release sb = 0, FSM = IDLE and div_timeout_o = 0. A rd=0 div sets no scoreboard bit.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
//
// Purpose: stage indices, divider FSM encoding, stall/flush patterns and
// register-address constants shared by pipe_hazard_ctrl and reg_scoreboard.
// Ports: none (package).
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] NOP_REG_ADDR = '0;

  // Bit positions inside the {wb,mem,ex,id,if} stall/flush vectors.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [0:0] {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  localparam logic [4:0] STALL_NONE   = 5'b00000;
  localparam logic [4:0] STALL_HAZARD = 5'b00011;  // hold IF and ID
  localparam logic [4:0] FLUSH_NONE   = 5'b00000;
  localparam logic [4:0] FLUSH_HAZARD = 5'b00100;  // bubble into EX
  localparam logic [4:0] FLUSH_JUMP   = 5'b00110;  // kill wrong-path ID and EX

endpackage

// File: rtl/pipe_hazard_ctrl_reg_scoreboard.sv
// rtl/pipe_hazard_ctrl_reg_scoreboard.sv - pending-write register scoreboard
//
// Purpose: one busy bit per integer register, set when a long-latency writer
// issues and cleared when its result is produced. x0 is never tracked.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   set_en, set_addr     mark a register busy at the next edge
//   clr_en, clr_addr     mark a register free at the next edge
//   rd1/rd2_addr, _busy  read ports for rs1/rs2
//   chk_addr, chk_busy   read port for the destination (WAW check)
module reg_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rd1_addr,
  input  logic [REG_AW-1:0] rd2_addr,
  input  logic [REG_AW-1:0] chk_addr,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic              chk_busy
);

  logic [REG_NUM-1:0] sb;
  logic [REG_NUM-1:0] set_vec;
  logic [REG_NUM-1:0] clr_vec;
  logic [REG_NUM-1:0] view;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && set_addr != '0) set_vec[set_addr] = 1'b1;
    if (clr_en) clr_vec[clr_addr] = 1'b1;
  end

  // Reads see a same-cycle clear: the result is being produced this cycle,
  // so a consumer (or a same-rd writer) need not wait another cycle.
  assign view = sb & ~clr_vec;

  assign rd1_busy = (rd1_addr != '0) && view[rd1_addr];
  assign rd2_busy = (rd2_addr != '0) && view[rd2_addr];
  assign chk_busy = (chk_addr != '0) && view[chk_addr];

  // Set is applied after clear so a set of the same index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= (sb & ~clr_vec) | set_vec;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - central stall/flush arbiter for the 5-stage pipeline
//
// Purpose: combines scoreboard RAW/WAW hazards, load-use, divider structural
// hazard and EX jumps into per-stage stall/flush vectors; tracks the single
// outstanding divide with a watchdog.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_*                       decode-stage operand / destination info
//   ex_*                       EX-stage load, destination and jump info
//   div_done_i / div_start_o   divider handshake
//   stall_o, flush_o           {wb,mem,ex,id,if} hold / bubble controls
//   div_busy_o, div_timeout_o  divider occupied, sticky watchdog error
module pipe_hazard_ctrl #(
  parameter int REG_NUM     = 32,
  parameter int REG_AW      = pipe_hazard_ctrl_pkg::REG_AW,
  parameter int DIV_TIMEOUT = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_reg1_raddr_i,
  input  logic              id_reg1_read_i,
  input  logic [REG_AW-1:0] id_reg2_raddr_i,
  input  logic              id_reg2_read_i,
  input  logic              id_reg_we_i,
  input  logic [REG_AW-1:0] id_reg_waddr_i,
  input  logic              id_is_div_i,
  input  logic              ex_is_load_i,
  input  logic              ex_reg_we_i,
  input  logic [REG_AW-1:0] ex_reg_waddr_i,
  input  logic              ex_jump_i,
  input  logic              div_done_i,
  output logic              div_start_o,
  output logic [4:0]        stall_o,
  output logic [4:0]        flush_o,
  output logic              div_busy_o,
  output logic              div_timeout_o
);
  import pipe_hazard_ctrl_pkg::*;

  localparam int WD_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);

  div_state_e        state_q, state_d;
  logic [REG_AW-1:0] div_rd_q, div_rd_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;

  logic rs1_busy, rs2_busy, rd_busy;
  logic raw_sb, waw_sb, load_use, div_struct;
  logic wd_hit, div_clr, issue;
  logic [4:0] stall, flush;

  reg_scoreboard #(.REG_NUM(REG_NUM), .REG_AW(REG_AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue),
    .set_addr (id_reg_waddr_i),
    .clr_en   (div_clr),
    .clr_addr (div_rd_q),
    .rd1_addr (id_reg1_raddr_i),
    .rd2_addr (id_reg2_raddr_i),
    .chk_addr (id_reg_waddr_i),
    .rd1_busy (rs1_busy),
    .rd2_busy (rs2_busy),
    .chk_busy (rd_busy)
  );

  always_comb begin
    wd_hit  = (state_q == DIV_BUSY) && !div_done_i && (wd_cnt_q == WD_LAST);
    div_clr = (state_q == DIV_BUSY) && (div_done_i || wd_hit);

    raw_sb     = id_valid_i && ((id_reg1_read_i && rs1_busy) || (id_reg2_read_i && rs2_busy));
    waw_sb     = id_valid_i && id_reg_we_i && rd_busy;
    load_use   = ex_is_load_i && ex_reg_we_i && (ex_reg_waddr_i != NOP_REG_ADDR) &&
                 ((id_reg1_read_i && id_reg1_raddr_i == ex_reg_waddr_i) ||
                  (id_reg2_read_i && id_reg2_raddr_i == ex_reg_waddr_i));
    div_struct = id_valid_i && id_is_div_i && (state_q == DIV_BUSY) && !div_done_i;

    stall = STALL_NONE;
    flush = FLUSH_NONE;
    if (ex_jump_i) begin
      flush = FLUSH_JUMP;
    end else if (raw_sb || waw_sb || div_struct || load_use) begin
      stall = STALL_HAZARD;
      flush = FLUSH_HAZARD;
    end

    issue = id_valid_i && id_is_div_i && !stall[STG_ID] && !ex_jump_i;
  end

  always_comb begin
    state_d   = state_q;
    div_rd_d  = div_rd_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      DIV_IDLE: begin
        // A late div_done_i here has no effect.
        if (issue) begin
          state_d  = DIV_BUSY;
          div_rd_d = id_reg_waddr_i;
          wd_cnt_d = '0;
        end
      end
      DIV_BUSY: begin
        if (div_done_i) begin
          if (issue) begin
            div_rd_d = id_reg_waddr_i;
            wd_cnt_d = '0;
          end else begin
            state_d = DIV_IDLE;
          end
        end else if (wd_hit) begin
          timeout_d = 1'b1;
          state_d   = DIV_IDLE;
        end else if (wd_cnt_q != '1) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      div_rd_q  <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_rd_q  <= div_rd_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Combinational outputs are gated so nothing leaks out while in reset.
  assign stall_o       = rst_n ? stall : 5'b00000;
  assign flush_o       = rst_n ? flush : 5'b00000;
  assign div_start_o   = rst_n && issue;
  assign div_busy_o    = (state_q == DIV_BUSY);
  assign div_timeout_o = timeout_q;

endmodule
